// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / divide sequencer owning the HI/LO registers.
// Shift-add multiply or restoring divide on operand magnitudes, WIDTH iterations, sign fix-up at the end.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_or_mul,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hilo_wr,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    DZERO = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic               neg_q;
  logic               neg_r;
  logic               last;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign last  = (cnt == CW'(WIDTH - 1));
  assign mag_a = data_A[WIDTH-1] ? (~data_A + 1'b1) : data_A;
  assign mag_b = data_B[WIDTH-1] ? (~data_B + 1'b1) : data_B;

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    addend = acc[0] ? opnd : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    trial  = acc[2*WIDTH-1:WIDTH-1];
    diff   = trial - {1'b0, opnd};
    acc_nx = acc;
    if (is_mul)
      acc_nx = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nx = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_q ? (~acc_nx + 1'b1) : acc_nx;
    quo_fix  = neg_q ? (~acc_nx[WIDTH-1:0] + 1'b1) : acc_nx[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc_nx[2*WIDTH-1:WIDTH] + 1'b1) : acc_nx[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start)
          state_nx = (!div_or_mul && data_B == '0) ? DZERO : RUN;
      end
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      DZERO:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Status outputs are flops loaded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hilo_wr  <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE) || (state_nx == DZERO);
      div_zero <= (state_nx == DZERO);
      hilo_wr  <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_mul <= div_or_mul;
            neg_q  <= data_A[WIDTH-1] ^ data_B[WIDTH-1];
            neg_r  <= data_A[WIDTH-1];
            opnd   <= div_or_mul ? mag_a : mag_b;
            acc    <= {{WIDTH{1'b0}}, (div_or_mul ? mag_b : mag_a)};
            cnt    <= '0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            if (is_mul) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, signed mult/div results,
// divide-by-zero, ignored restarts and mid-operation reset.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         div_or_mul;
  logic [W-1:0] data_A;
  logic [W-1:0] data_B;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         hilo_wr;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .div_or_mul (div_or_mul),
    .data_A     (data_A),
    .data_B     (data_B),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hilo_wr    (hilo_wr),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents an operation for edge E0, then scrambles the operands to show they were latched.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start      = 1'b1;
    div_or_mul = op;
    data_A     = a;
    data_B     = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data_A = ~a;
    data_B = ~b;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 100);
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(op, a, b);
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_hilo_wr"}, 64'(hilo_wr), 64'd1);
    check({tag, "_div_zero"}, 64'(div_zero), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_hilo_wr_after"}, 64'(hilo_wr), 64'd0);
  endtask

  initial begin
    int ndone;
    int kdone;
    reset      = 1'b1;
    start      = 1'b0;
    div_or_mul = 1'b0;
    data_A     = '0;
    data_B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hilo_wr", 64'(hilo_wr), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op("mul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_47_7", 1'b0, 32'd47, 32'd7, 32'd5, 32'd6);

    // divide by zero: HI/LO keep 5/6
    issue(1'b0, 32'd9, 32'd0);
    check("dz_done", 64'(done), 64'd1);
    check("dz_div_zero", 64'(div_zero), 64'd1);
    check("dz_busy", 64'(busy), 64'd1);
    check("dz_hilo_wr", 64'(hilo_wr), 64'd0);
    check("dz_hi", 64'(hi), 64'd5);
    check("dz_lo", 64'(lo), 64'd6);
    @(posedge clk);
    @(negedge clk);
    check("dz_busy_after", 64'(busy), 64'd0);
    check("dz_done_after", 64'(done), 64'd0);
    check("dz_div_zero_after", 64'(div_zero), 64'd0);

    // restart requests through the whole run and the DONE cycle are ignored
    ndone = 0;
    kdone = 0;
    issue(1'b1, 32'd5, 32'hFFFF_FFFA);
    start      = 1'b1;
    div_or_mul = 1'b0;
    data_A     = 32'd100;
    data_B     = 32'd3;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        kdone = k;
        check("ign_hi", 64'(hi), 64'hFFFF_FFFF);
        check("ign_lo", 64'(lo), 64'hFFFF_FFE2);
      end
      if (k >= 33) start = 1'b0;
    end
    check("ign_done_count", 64'(ndone), 64'd1);
    check("ign_done_cycle", 64'(kdone), 64'd32);
    check("ign_busy_end", 64'(busy), 64'd0);

    // reset in the middle of a divide
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_3_4", 1'b1, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
